// File: rtl/gfx_bus_master.sv
// gfx_bus_master: host-side sequencer for the graphics array's 16-register bus.
// Writes an instruction and its arguments, polls status $F, optionally reads $D/$E.
module gfx_bus_master #(
    parameter int DIV        = 8,
    parameter int POLL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_mode_only,
    input  logic [7:0]  cmd_opcode,
    input  logic [87:0] cmd_args,
    input  logic [3:0]  cmd_nargs,
    input  logic        cmd_read_result,
    output logic        rsp_valid,
    output logic [7:0]  rsp_result0,
    output logic [7:0]  rsp_result1,
    output logic [7:0]  rsp_status,
    output logic        rsp_timeout,
    output logic        bus_phi2,
    output logic [3:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        bus_rw,
    output logic        bus_ce0,
    output logic        bus_ce1b
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(DIV / 2);
    localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_INSTR,
        S_WR_ARG,
        S_GAP,
        S_POLL,
        S_RD_R0,
        S_RD_R1,
        S_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nx;
    logic [3:0]    byte_cnt;
    logic [3:0]    arg_nxt;
    logic [3:0]    nargs_q;
    logic [3:0]    nargs_clamped;
    logic [7:0]    poll_cnt;
    logic [87:0]   args_q;
    logic          mode_q;
    logic          read_q;
    logic          last_phase;
    logic          stat_done;
    logic          active;

    assign last_phase    = (phase == PH_LAST);
    assign phase_nx      = last_phase ? '0 : phase + PW'(1);
    assign stat_done     = bus_rdata[7] & ~bus_rdata[0];
    assign active        = (state != S_IDLE) && (state != S_DONE);
    assign arg_nxt       = byte_cnt + 4'd1;
    assign nargs_clamped = (cmd_nargs > 4'd11) ? 4'd11 : cmd_nargs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_result0 <= '0;
            rsp_result1 <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b0;
            bus_phi2    <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_rw      <= 1'b1;
            bus_ce0     <= 1'b0;
            bus_ce1b    <= 1'b1;
            phase       <= '0;
            byte_cnt    <= '0;
            poll_cnt    <= '0;
            nargs_q     <= '0;
            args_q      <= '0;
            mode_q      <= 1'b0;
            read_q      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (active) begin
                phase    <= phase_nx;
                bus_phi2 <= (phase_nx >= PH_HIGH);
            end
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state       <= S_WR_INSTR;
                        cmd_ready   <= 1'b0;
                        mode_q      <= cmd_mode_only;
                        read_q      <= cmd_read_result;
                        args_q      <= cmd_args;
                        nargs_q     <= nargs_clamped;
                        rsp_timeout <= 1'b0;
                        rsp_result0 <= '0;
                        rsp_result1 <= '0;
                        phase       <= '0;
                        byte_cnt    <= '0;
                        poll_cnt    <= '0;
                        bus_addr    <= cmd_mode_only ? 4'h0 : 4'h1;
                        bus_wdata   <= cmd_opcode;
                        bus_rw      <= 1'b0;
                        bus_ce0     <= 1'b1;
                        bus_ce1b    <= 1'b0;
                    end
                end
                S_WR_INSTR: begin
                    if (last_phase) begin
                        if (mode_q || nargs_q == 4'd0) begin
                            state    <= mode_q ? S_DONE : S_GAP;
                            bus_rw   <= 1'b1;
                            bus_ce0  <= 1'b0;
                            bus_ce1b <= 1'b1;
                        end else begin
                            state     <= S_WR_ARG;
                            bus_addr  <= 4'h2;
                            bus_wdata <= args_q[7:0];
                        end
                    end
                end
                S_WR_ARG: begin
                    if (last_phase) begin
                        if (arg_nxt == nargs_q) begin
                            state    <= S_GAP;
                            bus_rw   <= 1'b1;
                            bus_ce0  <= 1'b0;
                            bus_ce1b <= 1'b1;
                        end else begin
                            byte_cnt  <= arg_nxt;
                            bus_addr  <= arg_nxt + 4'd2;
                            bus_wdata <= args_q[{arg_nxt, 3'b000} +: 8];
                        end
                    end
                end
                // Idle bus cycle lets the chip latch the execute write and raise busy.
                S_GAP: begin
                    if (last_phase) begin
                        state    <= S_POLL;
                        bus_addr <= 4'hF;
                        bus_rw   <= 1'b1;
                        bus_ce0  <= 1'b1;
                        bus_ce1b <= 1'b0;
                    end
                end
                S_POLL: begin
                    if (last_phase) begin
                        rsp_status <= bus_rdata;
                        poll_cnt   <= poll_cnt + 8'd1;
                        if (stat_done && read_q) begin
                            state    <= S_RD_R0;
                            bus_addr <= 4'hD;
                        end else if (stat_done || poll_cnt == POLL_LAST) begin
                            state       <= S_DONE;
                            rsp_timeout <= ~stat_done;
                            bus_ce0     <= 1'b0;
                            bus_ce1b    <= 1'b1;
                        end
                    end
                end
                S_RD_R0: begin
                    if (last_phase) begin
                        state       <= S_RD_R1;
                        rsp_result0 <= bus_rdata;
                        bus_addr    <= 4'hE;
                    end
                end
                S_RD_R1: begin
                    if (last_phase) begin
                        state       <= S_DONE;
                        rsp_result1 <= bus_rdata;
                        bus_ce0     <= 1'b0;
                        bus_ce1b    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b1;
                    cmd_ready <= 1'b1;
                    phase     <= '0;
                end
            endcase
        end
    end

endmodule
